// File: rtl/aes_key_sched_seq.sv
// aes_key_sched_seq -- iterative AES-128 key schedule.
//
// A start pulse loads the cipher key into round-key slot 0. Each following
// clock derives one more round key with a single shared SubWord unit, so all
// eleven round keys are ready ten cycles after the start edge. The cipher
// rounds read the keys through a combinational port.
//
// Ports
//   CLK100MHZ  in   1    system clock, rising edge
//   reset      in   1    asynchronous, active-high; clears all state
//   start      in   1    one-cycle request to expand key_in (restarts if busy)
//   key_in     in   128  cipher key, byte 0 in [127:120]; sampled when start=1
//   rd_addr    in   AW   round-key index 0..NR
//   round_key  out  128  rk[rd_addr]; zero when rd_addr > NR
//   busy       out  1    expansion in progress
//   key_ready  out  1    every round key is valid for the current key
//
// State   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no key loaded since reset
// EXPAND  | writing rk[cnt] from rk[cnt-1], cnt runs 1..NR
// DONE    | rk[0..NR] valid; cnt holds at NR until the next start

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte of the packed table.
    logic [10:0] base;
    assign base = 11'd2047 - {a, 3'b000};
    assign y    = SBOX_TABLE[base -: 8];
endmodule

module aes_key_sched_seq #(
    parameter int NR = 10,  // only 10 (AES-128) is supported
    parameter int AW = 4
) (
    input  logic          CLK100MHZ,
    input  logic          reset,
    input  logic          start,
    input  logic [127:0]  key_in,
    input  logic [AW-1:0] rd_addr,
    output logic [127:0]  round_key,
    output logic          busy,
    output logic          key_ready
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state, state_next;
    logic [3:0]   cnt;
    logic [127:0] rk_file [0:NR];
    logic         load, step;
    logic [127:0] prev_rk, next_rk;
    logic [7:0]   rcon;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  w0n, w1n, w2n, w3n;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A start in any state restarts from the new key, so it overrides stepping.
    always_comb begin
        state_next = state;
        load       = start;
        step       = 1'b0;
        busy       = 1'b0;
        key_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (!start) begin
                    step = 1'b1;
                    if (cnt == 4'(NR)) state_next = DONE;
                end
            end
            DONE: begin
                key_ready = 1'b1;
                if (start) state_next = EXPAND;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prev_rk = rk_file[0];
        for (int k = 1; k <= NR; k++) begin
            if (cnt == 4'(k)) prev_rk = rk_file[k-1];
        end
    end

    always_comb begin
        case (cnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // RotWord then SubWord on the last word of the previous round key.
    assign rot_w = {prev_rk[23:0], prev_rk[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot_w[8*g +: 8]),
            .y (sub_w[8*g +: 8])
        );
    end

    assign t_w     = sub_w ^ {rcon, 24'h0};
    assign w0n     = prev_rk[127:96] ^ t_w;
    assign w1n     = prev_rk[95:64]  ^ w0n;
    assign w2n     = prev_rk[63:32]  ^ w1n;
    assign w3n     = prev_rk[31:0]   ^ w2n;
    assign next_rk = {w0n, w1n, w2n, w3n};

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
            for (int k = 0; k <= NR; k++) rk_file[k] <= '0;
        end else if (load) begin
            rk_file[0] <= key_in;
            cnt        <= 4'd1;
        end else if (step) begin
            for (int k = 1; k <= NR; k++) begin
                if (cnt == 4'(k)) rk_file[k] <= next_rk;
            end
            // The counter parks at NR; only a new start reloads it.
            if (cnt != 4'(NR)) cnt <= cnt + 4'd1;
        end
    end

    always_comb begin
        round_key = '0;
        for (int k = 0; k <= NR; k++) begin
            if (rd_addr == AW'(k)) round_key = rk_file[k];
        end
    end
endmodule
